mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the pipelined core, sitting directly downstream of the execute stage. It receives decoded control, ALU result, store data and destination index from execute, drives a request/acknowledge data-memory port for LOAD and STORE, and presents a registered writeback bundle to the writeback stage. The upstream pipeline stalls while a memory access is outstanding.

## Interface
- `TIMEOUT`, 15: maximum cycles a request waits for `mem_ack`; only used with `MEM_TIMEOUT_EN`.
- `clk` in 1: pipeline clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `valid_in` in 1: the execute bundle is valid this cycle.
- `control_in` in 5: control word from execute; bits [3:0] are the opcode.
- `result_in` in 16: ALU result; this is the memory address for LOAD and STORE.
- `store_data` in 16: write data for STORE.
- `dest_index_in` in 6: destination register index.
- `write_enable_in` in 1: register-write request from execute.
- `stall_out` out 1: upstream must hold its bundle; `valid_in` is ignored while high.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 16: memory address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: read data; valid when `mem_ack` = 1.
- `mem_ack` in 1: request completes this cycle.
- `wb_valid` out 1: writeback bundle is valid; one-cycle pulse per accepted instruction.
- `wb_control` out 5: control word passed through.
- `wb_dest_index` out 6: destination index passed through.
- `wb_data` out 16: value to write back.
- `wb_write_enable` out 1: register-file write strobe.
- `mem_error` out 1: one-cycle pulse on a timeout.

## Operation
- Opcodes: LOAD 4'b1100 and STORE 4'b1110 are memory ops. NOP is 4'b0000. Every other opcode is a pass-through op.
- FSM states: IDLE and ACCESS.
- IDLE with `valid_in` = 1 and a pass-through op. On the edge:
  - `wb_valid` = 1.
  - `wb_data` = `result_in`.
  - `wb_write_enable` = `write_enable_in`.
  - `wb_control` and `wb_dest_index` copy the inputs.
  - The FSM stays in IDLE.
- NOP is handled like a pass-through op, except `wb_write_enable` is forced to 0.
- IDLE with `valid_in` = 1 and a memory op. On the edge:
  - Latch control, destination index, address and data.
  - Set `mem_req` = 1, `mem_we` = (op == STORE), `mem_addr` = `result_in`, `mem_wdata` = `store_data`.
  - Go to ACCESS. `wb_valid` = 0.
- ACCESS behaviour:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` hold stable until completion.
  - On an edge with `mem_ack` = 1: `mem_req` goes to 0 and the FSM returns to IDLE. `wb_valid` = 1 with the latched control and destination index.
  - LOAD completion: `wb_data` = `mem_rdata`, `wb_write_enable` = 1, regardless of `write_enable_in`.
  - STORE completion: `wb_data` = 0, `wb_write_enable` = 0.
- `stall_out` = (state == ACCESS). It is combinational from the state register.
- `mem_ack` is ignored in IDLE.
- `wb_*` outputs are registered. When `wb_valid` = 0, `wb_write_enable` = 0. The other `wb_*` fields hold their last values.
- Reset, including mid-access:
  - Next state is IDLE.
  - `mem_req`, `mem_we`, `wb_valid`, `wb_write_enable` and `mem_error` are 0.
  - `mem_addr`, `mem_wdata`, `wb_data`, `wb_control` and `wb_dest_index` are 0.
  - An aborted access produces no writeback and no error.

## Timing
- Pass-through latency: accepted at edge N gives `wb_valid` in the cycle after edge N (1 cycle).
- Memory latency: accepted at edge N, so `mem_req` is high from the cycle after edge N. If `mem_ack` is sampled at edge M > N, `wb_valid` is high in the cycle after edge M. The minimum is 2 cycles.
- `stall_out` is high from the cycle after edge N through the cycle in which `mem_ack` is sampled.
- The next bundle is accepted at the first IDLE edge, M+1. It can reach writeback in the cycle after M+1, so there is no bubble beyond the access.
- Back-to-back pass-through ops sustain one `wb_valid` per cycle.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter runs while in ACCESS.
  - If `TIMEOUT` cycles elapse with no `mem_ack`, then on that edge: `mem_req` goes to 0, the FSM returns to IDLE, and `mem_error` pulses for 1 cycle.
  - At the same time `wb_valid` = 1 with `wb_write_enable` = 0 and `wb_data` = 0.
  - If `mem_ack` arrives on the expiry edge, the ack wins and there is no error.
  - The counter clears on entry to ACCESS.
- `MEM_TIMEOUT_EN` undefined: no counter. ACCESS waits indefinitely and `mem_error` is tied to 0.

## Test plan
- Reset: assert `reset` with `mem_ack` toggling. All outputs read 0, `stall_out` = 0, and no `wb_valid`.
- ADD pass-through: `valid_in`, opcode 4'b0010, `result_in` 16'h1234, dest 6'd5, `write_enable_in` 1. Next cycle: `wb_valid` = 1, `wb_data` = 16'h1234, `wb_dest_index` = 5, `wb_write_enable` = 1, `mem_req` = 0.
- LOAD with 3-cycle ack: addr 16'h0040, `mem_rdata` 16'hBEEF. During the access `mem_req` = 1, `mem_we` = 0, `mem_addr` = 16'h0040 stable, and `stall_out` = 1 for 3 cycles. The cycle after the ack: `wb_data` = 16'hBEEF, `wb_write_enable` = 1.
- STORE then ADD held upstream: STORE addr 16'h0010, data 16'h00AA, ack after 1 cycle.
  - `mem_we` = 1 and `mem_wdata` = 16'h00AA.
  - The STORE writeback has `wb_write_enable` = 0.
  - The ADD is accepted after the stall drops, and its `wb_valid` appears in the cycle right after the STORE's.
- Reset mid-access: LOAD is in ACCESS, then `reset` for 1 cycle, then `mem_ack` = 1. Result: `mem_req` = 0 after the reset edge, and no `wb_valid` or `mem_error` ever appears.
- `MEM_TIMEOUT_EN` with `TIMEOUT` = 4: LOAD with no ack. After 4 ACCESS cycles: `mem_error` pulses once, `wb_valid` = 1 with `wb_write_enable` = 0, and `stall_out` = 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: forwards pass-through ops to writeback and runs LOAD/STORE over a req/ack memory port.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that see no mem_ack within TIMEOUT cycles.
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [4:0]  control_in,
    input  logic [15:0] result_in,
    input  logic [15:0] store_data,
    input  logic [5:0]  dest_index_in,
    input  logic        write_enable_in,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_control,
    output logic [5:0]  wb_dest_index,
    output logic [15:0] wb_data,
    output logic        wb_write_enable,
    output logic        mem_error
);

    localparam int unsigned CTRL_W = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 6;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b1100;
    localparam logic [3:0] OP_STORE = 4'b1110;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   lat_control_q, lat_control_d;
    logic [IDX_W-1:0]    lat_dest_q, lat_dest_d;

    logic                mem_req_d, mem_we_d;
    logic [DATA_W-1:0]   mem_addr_d, mem_wdata_d;
    logic                wb_valid_d, wb_write_enable_d, mem_error_d;
    logic [CTRL_W-1:0]   wb_control_d;
    logic [IDX_W-1:0]    wb_dest_index_d;
    logic [DATA_W-1:0]   wb_data_d;

    logic [3:0]          opcode;
    logic                is_mem_op;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
    logic                unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign opcode    = control_in[3:0];
    assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign stall_out = (state_q == ACCESS);

    // Next-state and next-output logic
    always_comb begin
        state_d           = state_q;
        lat_control_d     = lat_control_q;
        lat_dest_d        = lat_dest_q;
        mem_req_d         = mem_req;
        mem_we_d          = mem_we;
        mem_addr_d        = mem_addr;
        mem_wdata_d       = mem_wdata;
        wb_valid_d        = 1'b0;
        wb_write_enable_d = 1'b0;
        wb_control_d      = wb_control;
        wb_dest_index_d   = wb_dest_index;
        wb_data_d         = wb_data;
        mem_error_d       = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d             = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (is_mem_op) begin
                        lat_control_d = control_in;
                        lat_dest_d    = dest_index_in;
                        mem_req_d     = 1'b1;
                        mem_we_d      = (opcode == OP_STORE);
                        mem_addr_d    = result_in;
                        mem_wdata_d   = store_data;
                        state_d       = ACCESS;
`ifdef MEM_TIMEOUT_EN
                        cnt_d         = '0;
`endif
                    end else begin
                        wb_valid_d        = 1'b1;
                        wb_data_d         = result_in;
                        wb_write_enable_d = write_enable_in && (opcode != OP_NOP);
                        wb_control_d      = control_in;
                        wb_dest_index_d   = dest_index_in;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d           = IDLE;
                    mem_req_d         = 1'b0;
                    mem_we_d          = 1'b0;
                    wb_valid_d        = 1'b1;
                    wb_control_d      = lat_control_q;
                    wb_dest_index_d   = lat_dest_q;
                    if (lat_control_q[3:0] == OP_LOAD) begin
                        wb_data_d         = mem_rdata;
                        wb_write_enable_d = 1'b1;
                    end else begin
                        wb_data_d         = '0;
                        wb_write_enable_d = 1'b0;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Expired with no ack: abort and hand writeback an empty bundle
                    state_d         = IDLE;
                    mem_req_d       = 1'b0;
                    mem_we_d        = 1'b0;
                    mem_error_d     = 1'b1;
                    wb_valid_d      = 1'b1;
                    wb_data_d       = '0;
                    wb_control_d    = lat_control_q;
                    wb_dest_index_d = lat_dest_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            lat_control_q   <= '0;
            lat_dest_q      <= '0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            wb_valid        <= 1'b0;
            wb_write_enable <= 1'b0;
            wb_control      <= '0;
            wb_dest_index   <= '0;
            wb_data         <= '0;
            mem_error       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            lat_control_q   <= lat_control_d;
            lat_dest_q      <= lat_dest_d;
            mem_req         <= mem_req_d;
            mem_we          <= mem_we_d;
            mem_addr        <= mem_addr_d;
            mem_wdata       <= mem_wdata_d;
            wb_valid        <= wb_valid_d;
            wb_write_enable <= wb_write_enable_d;
            wb_control      <= wb_control_d;
            wb_dest_index   <= wb_dest_index_d;
            wb_data         <= wb_data_d;
            mem_error       <= mem_error_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instruction stream
// checked cycle by cycle against an opcode-level reference model.
module tb_mem_stage;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam logic [3:0]  LOAD  = 4'b1100;
    localparam logic [3:0]  STORE = 4'b1110;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [4:0]  control_in = '0;
    logic [15:0] result_in = '0;
    logic [15:0] store_data = '0;
    logic [5:0]  dest_index_in = '0;
    logic        write_enable_in = 1'b0;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_control;
    logic [5:0]  wb_dest_index;
    logic [15:0] wb_data;
    logic        wb_write_enable;
    logic        mem_error;

    mem_stage #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .control_in(control_in),
        .result_in(result_in), .store_data(store_data), .dest_index_in(dest_index_in),
        .write_enable_in(write_enable_in), .stall_out(stall_out), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_control(wb_control),
        .wb_dest_index(wb_dest_index), .wb_data(wb_data), .wb_write_enable(wb_write_enable),
        .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Last writeback bundle the model expects the stage to be holding
    logic [15:0] last_data = '0;
    logic [4:0]  last_ctrl = '0;
    logic [5:0]  last_dest = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " wb_valid"}, 32'(wb_valid), 32'd0);
        check({tag, " wb_we"}, 32'(wb_write_enable), 32'd0);
        check({tag, " wb_data hold"}, 32'(wb_data), 32'(last_data));
        check({tag, " wb_ctrl hold"}, 32'(wb_control), 32'(last_ctrl));
        check({tag, " wb_dest hold"}, 32'(wb_dest_index), 32'(last_dest));
        check({tag, " mem_error"}, 32'(mem_error), 32'd0);
    endtask

    task automatic idle_cycle();
        valid_in  = 1'b0;
        mem_ack   = 1'($urandom);
        mem_rdata = 16'($urandom);
        tick();
        check_quiet("idle");
        check("idle stall", 32'(stall_out), 32'd0);
        check("idle mem_req", 32'(mem_req), 32'd0);
    endtask

    // Issue one instruction; memory ops see d non-ack ACCESS edges, then an ack
    task automatic run_op(input logic [4:0] ctrl, input logic [15:0] res, input logic [15:0] sd,
                          input logic [5:0] dest, input logic we, input int d);
        logic [3:0]  op;
        logic [15:0] rd;
        logic        exp_we;
        logic [15:0] exp_data;
        op = ctrl[3:0];
        valid_in        = 1'b1;
        control_in      = ctrl;
        result_in       = res;
        store_data      = sd;
        dest_index_in   = dest;
        write_enable_in = we;
        mem_ack         = 1'($urandom);
        mem_rdata       = 16'($urandom);
        tick();
        valid_in = 1'b0;
        if (op != LOAD && op != STORE) begin
            exp_we   = we && (op != 4'b0000);
            exp_data = res;
        end else begin
            for (int i = 0; i <= d; i++) begin
                check("acc stall", 32'(stall_out), 32'd1);
                check("acc mem_req", 32'(mem_req), 32'd1);
                check("acc mem_we", 32'(mem_we), 32'(op == STORE));
                check("acc mem_addr", 32'(mem_addr), 32'(res));
                check("acc mem_wdata", 32'(mem_wdata), 32'(sd));
                check("acc wb_valid", 32'(wb_valid), 32'd0);
                check("acc mem_error", 32'(mem_error), 32'd0);
                // Upstream noise while stalled must be ignored
                valid_in        = 1'($urandom);
                control_in      = 5'($urandom);
                result_in       = 16'($urandom);
                store_data      = 16'($urandom);
                dest_index_in   = 6'($urandom);
                write_enable_in = 1'($urandom);
                mem_ack         = (i == d);
                mem_rdata       = 16'($urandom);
                rd              = mem_rdata;
                tick();
            end
            valid_in = 1'b0;
            mem_ack  = 1'b0;
            exp_we   = (op == LOAD);
            exp_data = (op == LOAD) ? rd : 16'h0000;
        end
        check("wb_valid", 32'(wb_valid), 32'd1);
        check("wb_data", 32'(wb_data), 32'(exp_data));
        check("wb_we", 32'(wb_write_enable), 32'(exp_we));
        check("wb_control", 32'(wb_control), 32'(ctrl));
        check("wb_dest", 32'(wb_dest_index), 32'(dest));
        check("done mem_req", 32'(mem_req), 32'd0);
        check("done stall", 32'(stall_out), 32'd0);
        check("done mem_error", 32'(mem_error), 32'd0);
        last_data = exp_data;
        last_ctrl = ctrl;
        last_dest = dest;
    endtask

    initial begin
        // Reset with mem_ack toggling
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ack = ~mem_ack;
            tick();
        end
        check("rst stall", 32'(stall_out), 32'd0);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst mem_wdata", 32'(mem_wdata), 32'd0);
        check_quiet("rst");
        reset   = 1'b0;
        mem_ack = 1'b0;
        idle_cycle();

        // Directed: ADD, LOAD with 3-cycle ack, STORE then ADD back-to-back
        run_op({1'b0, 4'b0010}, 16'h1234, 16'h0000, 6'd5, 1'b1, 0);
        run_op({1'b0, LOAD}, 16'h0040, 16'h0000, 6'd7, 1'b0, 2);
        idle_cycle();
        run_op({1'b0, STORE}, 16'h0010, 16'h00AA, 6'd3, 1'b1, 0);
        run_op({1'b0, 4'b0010}, 16'h5555, 16'h0000, 6'd9, 1'b1, 0);
        run_op({1'b1, 4'b0000}, 16'h7777, 16'h0000, 6'd1, 1'b1, 0);
        idle_cycle();

        // Reset in the middle of a LOAD: no writeback, no error afterwards
        valid_in      = 1'b1;
        control_in    = {1'b0, LOAD};
        result_in     = 16'h0080;
        dest_index_in = 6'd2;
        mem_ack       = 1'b0;
        tick();
        valid_in = 1'b0;
        check("mid mem_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid rst mem_req", 32'(mem_req), 32'd0);
        check("mid rst stall", 32'(stall_out), 32'd0);
        last_data = '0;
        last_ctrl = '0;
        last_dest = '0;
        check_quiet("mid rst");
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1;
            tick();
            check_quiet("post rst");
        end
        mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // LOAD with no ack expires after TB_TIMEOUT ACCESS cycles
        valid_in      = 1'b1;
        control_in    = {1'b0, LOAD};
        result_in     = 16'h0100;
        dest_index_in = 6'd4;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < int'(TB_TIMEOUT); i++) begin
            check("to stall", 32'(stall_out), 32'd1);
            check("to wb_valid", 32'(wb_valid), 32'd0);
            check("to mem_error", 32'(mem_error), 32'd0);
            tick();
        end
        check("to err pulse", 32'(mem_error), 32'd1);
        check("to wb_valid", 32'(wb_valid), 32'd1);
        check("to wb_we", 32'(wb_write_enable), 32'd0);
        check("to wb_data", 32'(wb_data), 32'd0);
        check("to stall end", 32'(stall_out), 32'd0);
        check("to mem_req", 32'(mem_req), 32'd0);
        last_data = '0;
        last_ctrl = {1'b0, LOAD};
        last_dest = 6'd4;
        idle_cycle();
`endif

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            int unsigned k;
            logic [4:0]  c;
            k = $urandom_range(0, 9);
            c = 5'($urandom);
            if (k < 2) begin
                idle_cycle();
            end else begin
                if (k < 4)       c[3:0] = LOAD;
                else if (k < 6)  c[3:0] = STORE;
                else if (k == 6) c[3:0] = 4'b0000;
                run_op(c, 16'($urandom), 16'($urandom), 6'($urandom), 1'($urandom),
                       int'($urandom_range(0, TB_TIMEOUT - 1)));
            end
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
